serial_addsub_ctrl: RTL and testbench
=====================================

// Module: serial_addsub_ctrl
// PURPOSE
//  Sequencer that time-shares one full_adder_1bit cell to do WIDTH-bit add/subtract,
//  one bit per clock, LSB first. Latches operands on a start handshake and steps the
//  adder through every bit position. Produces a signed-saturating (paddsub-style)
//  result with overflow flag. Low-area alternative to the ripple paddsub datapath.
// PARAMETERS
//  WIDTH  16  operand/result width in bits (>=2)
//  SAT    1   1: saturate result on signed overflow; 0: wrap (raw sum)
// PORTS
//  clk    in   1      single clock, rising edge
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request; accepted only in IDLE or DONE
//  sub    in   1      0: a+b, 1: a-b; sampled with start
//  a      in   WIDTH  operand A (two's complement); sampled with start
//  b      in   WIDTH  operand B (two's complement); sampled with start
//  busy   out  1      high while in RUN
//  done   out  1      one-cycle pulse: result valid
//  sum    out  WIDTH  result, held from done until next accepted start
//  ovfl   out  1      signed overflow of the operation, held with sum
//  cout   out  1      raw carry out of MSB, held with sum
// BEHAVIOUR
//  Reset (sync, rst=1 at edge): state=IDLE; busy=0, done=0, sum=0, ovfl=0, cout=0,
//   bit counter=0, carry reg=0. Reset mid-RUN aborts; no done is produced.
//  FSM: IDLE -start-> RUN; RUN -(cnt==WIDTH-1)-> DONE; DONE -start-> RUN; DONE -!start-> IDLE.
//  Accept edge: a_r<=a; b_r<=sub ? ~b : b; carry<=sub; cnt<=0; sum/ovfl/cout unchanged
//   until the new done.
//  RUN edge k (k=0..WIDTH-1): FA inputs a_r[k], b_r[k], carry; result bit k shifted in,
//   carry<=FA cout. At k=WIDTH-1 also capture c_in_msb (carry into MSB).
//  Latency: done=1 during the cycle following the WIDTH-th edge after the accept edge;
//   i.e. start accepted at edge 0 -> done high between edges WIDTH and WIDTH+1.
//  busy=1 for exactly WIDTH cycles per operation; busy and done never both high.
//  Arithmetic: raw = a + (sub ? ~b+1 : b) mod 2^WIDTH; cout = carry out of MSB;
//   ovfl = c_in_msb ^ cout.
//  Saturation (SAT=1, ovfl=1): sum = a[MSB] ? {1,0..0} (most neg) : {0,1..1} (most pos).
//   SAT=0: sum = raw, ovfl still reported.
//  start while busy: ignored, no queuing, operands not re-sampled.
//  start in DONE cycle: accepted (back-to-back); done drops next cycle, busy rises.
//  sub=1 with b = most-negative: handled by ~b+carry-in, overflow flagged normally.
//  sum/ovfl/cout update only at the RUN->DONE edge; stable otherwise.
// STRUCTURE
//  Shared header paddsub_defs.vh: FSM state encodings (ST_IDLE=2'd0, ST_RUN=2'd1,
//   ST_DONE=2'd2) and saturation constant macros parameterised by WIDTH.
//  One sub-module: existing full_adder_1bit (ports cout, a, b, cin, sum), single instance.
//  Controller holds FSM, $clog2(WIDTH) counter, operand shift regs, carry reg, result
//   shift reg, saturation mux. No other hierarchy.
// TESTING (WIDTH=16, SAT=1 unless noted; check with ===, fail message + $finish on error)
//  1) a=16'h1234, b=16'h0F0F, sub=0 -> done 16 cycles after accept; sum=16'h2143, ovfl=0.
//  2) a=16'h0005, b=16'h0007, sub=1 -> sum=16'hFFFE, ovfl=0, cout=0.
//  3) a=16'h7FFF, b=16'h0001, sub=0 -> sum=16'h7FFF, ovfl=1; same with SAT=0 -> 16'h8000, ovfl=1.
//  4) a=16'h8000, b=16'h0001, sub=1 -> sum=16'h8000, ovfl=1, cout=1.
//  5) start pulsed mid-RUN with new operands -> ignored; first result unchanged; start held
//     in DONE -> second op accepted back-to-back, busy high next cycle, done 1 cycle only.
//  6) rst at RUN cycle 7 -> next cycle busy=0, done=0, sum=0; no done pulse; new op completes correctly.

Source files
------------

// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
package serial_addsub_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Most-positive / most-negative two's complement constants for a given width.
    function automatic logic [63:0] sat_pos(input int unsigned width);
        logic [63:0] v;
        v = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i < width - 1) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic [63:0] sat_neg(input int unsigned width);
        logic [63:0] v;
        v = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i == width - 1) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/serial_addsub_ctrl_fa.sv
// Single-bit full adder cell shared by the serial add/subtract sequencer.
module full_adder_1bit (
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial two's complement add/subtract, LSB first through one shared full adder,
// with optional signed saturation of the result.
module serial_addsub_ctrl
    import serial_addsub_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter bit          SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             ovfl,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos(WIDTH));
    localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg(WIDTH));

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               last;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               carry;
    logic [WIDTH-2:0]   res_r;
    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   raw;
    logic               ovf_now;
    logic [WIDTH-1:0]   result;

    // State register; busy/done are flopped from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == ST_RUN);
            done  <= (state_nxt == ST_DONE);
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    last      = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    full_adder_1bit u_fa (
        .cout (fa_cout),
        .a    (a_r[0]),
        .b    (b_r[0]),
        .cin  (carry),
        .sum  (fa_sum)
    );

    // On the final bit the shifted-down a_r[0] is the original sign of a, and carry
    // is the carry into the MSB.
    assign raw     = {fa_sum, res_r};
    assign ovf_now = carry ^ fa_cout;
    assign result  = (SAT && ovf_now) ? (a_r[0] ? SAT_NEG : SAT_POS) : raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            res_r <= '0;
            sum   <= '0;
            ovfl  <= 1'b0;
            cout  <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub;
        end else if (state == ST_RUN) begin
            cnt   <= cnt + CNT_W'(1);
            a_r   <= a_r >> 1;
            b_r   <= b_r >> 1;
            carry <= fa_cout;
            res_r <= raw[WIDTH-1:1];
            if (last) begin
                sum  <= result;
                ovfl <= ovf_now;
                cout <= fa_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Randomized and directed checks of serial_addsub_ctrl against an arithmetic reference.
module tb_serial_addsub_ctrl;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy, done, ovfl, cout;
    logic [W-1:0] sum;
    logic         busy0, done0, ovfl0, cout0;
    logic [W-1:0] sum0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_addsub_ctrl #(.WIDTH(W), .SAT(1'b1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .ovfl(ovfl), .cout(cout)
    );

    serial_addsub_ctrl #(.WIDTH(W), .SAT(1'b0)) u_dut_wrap (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy0), .done(done0), .sum(sum0), .ovfl(ovfl0), .cout(cout0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on the operands.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                         output logic [W-1:0] wrap, output logic [W-1:0] sat,
                         output logic mo, output logic mc);
        int   sa, sb, r;
        logic [W:0] full;
        sa   = int'($signed(ma));
        sb   = int'($signed(mb));
        r    = msub ? sa - sb : sa + sb;
        mo   = (r > 32767) || (r < -32768);
        full = {1'b0, ma} + {1'b0, (msub ? ~mb : mb)} + (W+1)'(msub);
        mc   = full[W];
        wrap = full[W-1:0];
        sat  = mo ? (r < 0 ? 16'h8000 : 16'h7FFF) : wrap;
    endtask

    // Called at a negedge; leaves the bench at the negedge after the accept edge.
    task automatic launch(input logic [W-1:0] la, input logic [W-1:0] lb, input logic ls);
        a     = la;
        b     = lb;
        sub   = ls;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done, optionally pulsing start with junk operands mid-run; returns at the done negedge.
    task automatic finish_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                             input logic os, input int inject);
        logic [W-1:0] ew, es;
        logic         eo, ec;
        int           lat, nbusy, nboth;
        model(oa, ob, os, ew, es, eo, ec);
        lat   = 1;
        nbusy = 0;
        nboth = 0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            if (busy && done) nboth++;
            if (lat == inject) begin
                a     = W'($urandom);
                b     = W'($urandom);
                sub   = 1'($urandom);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(W + 1));
        check({tag, " busy_cycles"}, 32'(nbusy), 32'(W));
        check({tag, " busy_done_overlap"}, 32'(nboth), 32'd0);
        check({tag, " sum"}, 32'(sum), 32'(es));
        check({tag, " ovfl"}, 32'(ovfl), 32'(eo));
        check({tag, " cout"}, 32'(cout), 32'(ec));
        check({tag, " wrap_sum"}, 32'(sum0), 32'(ew));
        check({tag, " wrap_ovfl"}, 32'(ovfl0), 32'(eo));
        check({tag, " wrap_done"}, 32'(done0), 32'd1);
    endtask

    task automatic op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                      input logic os);
        logic [W-1:0] held;
        launch(oa, ob, os);
        finish_op(tag, oa, ob, os, 0);
        held = sum;
        @(negedge clk);
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " sum_held"}, 32'(sum), 32'(held));
    endtask

    initial begin
        logic [W-1:0] ra, rb, ra2, rb2;
        logic         rs, rs2;
        int           ndone;

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset ovfl_cout", {30'd0, ovfl, cout}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        op("t1_add", 16'h1234, 16'h0F0F, 1'b0);
        check("t1_const", 32'(sum), 32'h2143);
        op("t2_sub", 16'h0005, 16'h0007, 1'b1);
        check("t2_const", 32'(sum), 32'hFFFE);
        op("t3_posovf", 16'h7FFF, 16'h0001, 1'b0);
        check("t3_const_sat", 32'(sum), 32'h7FFF);
        check("t3_const_wrap", 32'(sum0), 32'h8000);
        op("t4_negovf", 16'h8000, 16'h0001, 1'b1);
        check("t4_const", {15'd0, sum, ovfl}, {15'd0, 16'h8000, 1'b1});
        op("sub_minneg", 16'h0000, 16'h8000, 1'b1);
        op("sub_minneg2", 16'hFFFF, 16'h8000, 1'b1);

        // Start mid-run is ignored; start held in DONE is accepted back-to-back.
        ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
        ra2 = W'($urandom); rb2 = W'($urandom); rs2 = 1'($urandom);
        launch(ra, rb, rs);
        finish_op("t5_first", ra, rb, rs, 5);
        launch(ra2, rb2, rs2);
        check("t5_b2b busy", 32'(busy), 32'd1);
        check("t5_b2b done", 32'(done), 32'd0);
        finish_op("t5_second", ra2, rb2, rs2, 0);
        @(negedge clk);
        check("t5 done_pulse", 32'(done), 32'd0);

        // Reset during RUN cycle 7 aborts with no done.
        launch(16'h4321, 16'h1111, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6 busy", 32'(busy), 32'd0);
        check("t6 done", 32'(done), 32'd0);
        check("t6 sum", 32'(sum), 32'd0);
        check("t6 wrap_sum", 32'(sum0), 32'd0);
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || done0) ndone++;
        end
        check("t6 no_done", 32'(ndone), 32'd0);
        op("t6_after", 16'h4321, 16'h1111, 1'b0);

        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            if (i % 5 == 0) ra = {ra[W-1], {(W-1){~ra[W-1]}}};
            op("rand", ra, rb, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
